// File: rtl/pio_in_debounce_irq.sv
// N-channel Avalon-MM input PIO: synchroniser, per-channel debounce, rise/fall edge capture, masked IRQ.
// Define PIO_IN_BITCLEAR_EN for write-1-to-clear EDGE_CAPTURE; otherwise any write clears every bit.
module pio_in_debounce_irq #(
  parameter int WIDTH       = 5,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_W       = 16,
  parameter int DEB_RESET   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  typedef enum logic [2:0] {
    REG_DATA       = 3'd0,
    REG_DEB_PERIOD = 3'd1,
    REG_IRQ_MASK   = 3'd2,
    REG_EDGE_CAP   = 3'd3,
    REG_RISE_EN    = 3'd4,
    REG_FALL_EN    = 3'd5
  } reg_addr_e;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] synced;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d;
  logic [DEB_W-1:0] cnt [WIDTH];
  logic [DEB_W-1:0] deb_period;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] cap_clr;
  logic [31:0]      rd_next;
  logic             wr;
  logic             unused_wdata;

  assign wr           = chipselect & ~write_n;
  assign synced       = sync_q[SYNC_STAGES-1];
  assign unused_wdata = ^writedata;

  // NOTE: every flop here is a plain register (no RAM), so all of them, including
  // the counter array, take the synchronous reset; sequential state uses <= only.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  // A change must be seen deb_period+1 consecutive cycles before stable follows it.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable   <= '0;
      stable_d <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      stable_d <= stable;
      for (int i = 0; i < WIDTH; i++) begin
        if (synced[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == deb_period) begin
          stable[i] <= synced[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  assign edge_set = (~stable_d & stable & rise_en) | (stable_d & ~stable & fall_en);

  // NOTE: always_comb outputs get a default first so no path can infer a latch.
  always_comb begin
    cap_clr = '0;
    if (wr && address == REG_EDGE_CAP) begin
`ifdef PIO_IN_BITCLEAR_EN
      cap_clr = writedata[WIDTH-1:0];
`else
      cap_clr = '1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      deb_period   <= DEB_W'(DEB_RESET);
      irq_mask     <= '0;
      rise_en      <= '0;
      fall_en      <= '0;
      edge_capture <= '0;
    end else begin
      if (wr && address == REG_DEB_PERIOD) deb_period <= writedata[DEB_W-1:0];
      if (wr && address == REG_IRQ_MASK)   irq_mask   <= writedata[WIDTH-1:0];
      if (wr && address == REG_RISE_EN)    rise_en    <= writedata[WIDTH-1:0];
      if (wr && address == REG_FALL_EN)    fall_en    <= writedata[WIDTH-1:0];
      // A new edge overrides a simultaneous clear of the same bit.
      edge_capture <= (edge_capture & ~cap_clr) | edge_set;
    end
  end

  always_comb begin
    rd_next = '0;
    case (reg_addr_e'(address))
      REG_DATA:       rd_next[WIDTH-1:0] = stable;
      REG_DEB_PERIOD: rd_next[DEB_W-1:0] = deb_period;
      REG_IRQ_MASK:   rd_next[WIDTH-1:0] = irq_mask;
      REG_EDGE_CAP:   rd_next[WIDTH-1:0] = edge_capture;
      REG_RISE_EN:    rd_next[WIDTH-1:0] = rise_en;
      REG_FALL_EN:    rd_next[WIDTH-1:0] = fall_en;
      default:        rd_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) readdata <= '0;
    else       readdata <= rd_next;
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_pio_in_debounce_irq.sv
// Self-checking bench for pio_in_debounce_irq: directed scenarios plus a randomized run
// against a run-length debounce model.
module tb_pio_in_debounce_irq;
  localparam int WIDTH     = 5;
  localparam int SYNC      = 2;
  localparam int DEB_W     = 16;
  localparam int DEB_RESET = 0;

  logic             clk = 1'b0;
  logic             reset;
  logic [2:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [WIDTH-1:0] in_port;
  logic [31:0]      readdata;
  logic             irq;

  int n_cmp = 0;
  int n_bad = 0;

  pio_in_debounce_irq #(
    .WIDTH(WIDTH), .SYNC_STAGES(SYNC), .DEB_W(DEB_W), .DEB_RESET(DEB_RESET)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    @(posedge clk);
    #1 d = readdata;
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    logic [31:0] exp;
    @(negedge clk);
    reset = 1'b1; in_port = '0;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (readdata !== 32'd0) begin
      n_bad++; $display("FAIL reset_readdata got=%h want=%h", readdata, 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if (irq !== 1'b0) begin
      n_bad++; $display("FAIL reset_irq got=%b want=0", irq);
    end
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), rd);
      exp = (a == 1) ? 32'(DEB_RESET) : 32'd0;
      n_cmp++;
      if (rd !== exp) begin
        n_bad++; $display("FAIL reset_reg%0d got=%h want=%h", a, rd, exp);
      end
    end
  endtask

  task automatic test_rise_timing;
    logic [31:0] rd;
    logic        exp;
    int          bad_cycles;
    bus_write(3'd1, 32'd4);
    bus_write(3'd4, 32'h01);
    bus_write(3'd5, 32'h00);
    bus_write(3'd2, 32'h01);
    bus_write(3'd3, 32'hFFFF_FFFF);
    address = 3'd0;
    in_port[0] = 1'b1;
    bad_cycles = 0;
    // stable rises SYNC+5 edges after the change; readdata and irq show it one edge later
    for (int k = 1; k <= SYNC + 8; k++) begin
      @(posedge clk);
      #1;
      exp = (k >= SYNC + 6);
      n_cmp++;
      if (readdata[0] !== exp || irq !== exp) begin
        n_bad++;
        $display("FAIL rise_timing cycle=%0d data0=%b irq=%b want=%b", k, readdata[0], irq, exp);
      end
    end
    bus_read(3'd3, rd);
    n_cmp++;
    if (rd !== 32'h01) begin
      n_bad++; $display("FAIL rise_capture got=%h want=%h", rd, 32'h01);
    end
  endtask

  task automatic test_glitch;
    logic [31:0] rd;
    int          seen_bit1;
    bus_write(3'd4, 32'h1F);
    bus_write(3'd5, 32'h1F);
    bus_write(3'd3, 32'hFFFF_FFFF);
    address = 3'd0;
    in_port[1] = 1'b1;
    seen_bit1 = 0;
    for (int k = 0; k < 16; k++) begin
      if (k == 3) in_port[1] = 1'b0;
      @(posedge clk);
      #1;
      if (readdata[1] !== 1'b0) seen_bit1++;
      @(negedge clk);
    end
    n_cmp++;
    if (seen_bit1 != 0) begin
      n_bad++; $display("FAIL glitch_data cycles_high=%0d want=0", seen_bit1);
    end
    bus_read(3'd0, rd);
    n_cmp++;
    if (rd !== 32'h01) begin
      n_bad++; $display("FAIL glitch_data_final got=%h want=%h", rd, 32'h01);
    end
    bus_read(3'd3, rd);
    n_cmp++;
    if (rd !== 32'h00) begin
      n_bad++; $display("FAIL glitch_capture got=%h want=%h", rd, 32'h00);
    end
  endtask

  task automatic test_fall_irq;
    logic [31:0] rd;
    bus_write(3'd4, 32'h00);
    bus_write(3'd5, 32'h04);
    bus_write(3'd2, 32'h04);
    in_port[2] = 1'b1;
    repeat (12) @(negedge clk);
    n_cmp++;
    if (irq !== 1'b0) begin
      n_bad++; $display("FAIL fall_no_rise_irq got=%b want=0", irq);
    end
    in_port[2] = 1'b0;
    repeat (12) @(negedge clk);
    bus_read(3'd3, rd);
    n_cmp++;
    if (rd !== 32'h04) begin
      n_bad++; $display("FAIL fall_capture got=%h want=%h", rd, 32'h04);
    end
    n_cmp++;
    if (irq !== 1'b1) begin
      n_bad++; $display("FAIL fall_irq got=%b want=1", irq);
    end
    @(negedge clk);
    address = 3'd3; chipselect = 1'b1; write_n = 1'b0; writedata = 32'h04;
    @(posedge clk);
    #1;
    n_cmp++;
    if (irq !== 1'b0) begin
      n_bad++; $display("FAIL fall_irq_clear got=%b want=0", irq);
    end
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic test_clear_mode;
    logic [31:0] rd;
    logic [31:0] exp;
    bus_write(3'd4, 32'h03);
    bus_write(3'd5, 32'h03);
    bus_write(3'd2, 32'h00);
    bus_write(3'd3, 32'hFFFF_FFFF);
    in_port[0] = 1'b0;
    in_port[1] = 1'b1;
    repeat (12) @(negedge clk);
    bus_read(3'd3, rd);
    n_cmp++;
    if (rd !== 32'h03) begin
      n_bad++; $display("FAIL clear_setup got=%h want=%h", rd, 32'h03);
    end
    bus_write(3'd3, 32'h01);
    bus_read(3'd3, rd);
`ifdef PIO_IN_BITCLEAR_EN
    exp = 32'h02;
`else
    exp = 32'h00;
`endif
    n_cmp++;
    if (rd !== exp) begin
      n_bad++; $display("FAIL clear_mode got=%h want=%h", rd, exp);
    end
  endtask

  task automatic test_set_wins;
    logic [31:0] rd;
    bus_write(3'd4, 32'h08);
    bus_write(3'd5, 32'h00);
    bus_write(3'd2, 32'h08);
    bus_write(3'd3, 32'hFFFF_FFFF);
    in_port[3] = 1'b1;
    // capture sets on edge SYNC+6; the clear write is sampled on that same edge
    repeat (SYNC + 5) @(posedge clk);
    @(negedge clk);
    address = 3'd3; chipselect = 1'b1; write_n = 1'b0; writedata = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    n_cmp++;
    if (irq !== 1'b1) begin
      n_bad++; $display("FAIL set_wins_irq got=%b want=1", irq);
    end
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    bus_read(3'd3, rd);
    n_cmp++;
    if (rd !== 32'h08) begin
      n_bad++; $display("FAIL set_wins_capture got=%h want=%h", rd, 32'h08);
    end
  endtask

  task automatic test_random;
    logic [WIDTH-1:0] m_stable, m_stable_d, m_cap, m_synced, m_next, pins;
    logic [WIDTH-1:0] m_hist [SYNC];
    logic [WIDTH-1:0] exp_rd, re, fe;
    int               m_run [WIDTH];
    int               dp;
    logic [31:0]      rd;
    @(negedge clk);
    in_port = '0; reset = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
    reset = 1'b0;
    m_stable = '0; m_stable_d = '0; m_cap = '0; pins = '0;
    for (int k = 0; k < SYNC; k++) m_hist[k] = '0;
    for (int i = 0; i < WIDTH; i++) m_run[i] = 0;
    dp = $urandom_range(0, 3);
    re = WIDTH'($urandom);
    fe = WIDTH'($urandom);
    bus_write(3'd1, 32'(dp));
    bus_write(3'd4, 32'(re));
    bus_write(3'd5, 32'(fe));
    bus_write(3'd2, 32'hFFFF_FFFF);
    address = 3'd0;
    for (int c = 0; c < 500; c++) begin
      if (c < 480)
        for (int i = 0; i < WIDTH; i++)
          if ($urandom_range(0, 5) == 0) pins[i] = ~pins[i];
      in_port = pins;
      @(posedge clk);
      // model: a pin level reaches stable once it has differed for dp+1 cycles in a row
      exp_rd   = m_stable;
      m_cap    = m_cap | (~m_stable_d & m_stable & re) | (m_stable_d & ~m_stable & fe);
      m_synced = m_hist[SYNC-1];
      m_next   = m_stable;
      for (int i = 0; i < WIDTH; i++) begin
        if (m_synced[i] != m_stable[i]) begin
          m_run[i]++;
          if (m_run[i] == dp + 1) begin
            m_next[i] = m_synced[i];
            m_run[i]  = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_stable_d = m_stable;
      m_stable   = m_next;
      for (int k = SYNC - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = pins;
      #1;
      n_cmp++;
      if (readdata !== 32'(exp_rd) || irq !== (|m_cap)) begin
        n_bad++;
        $display("FAIL random cycle=%0d data=%h want=%h irq=%b want=%b",
                 c, readdata, 32'(exp_rd), irq, |m_cap);
      end
      @(negedge clk);
    end
    bus_read(3'd3, rd);
    n_cmp++;
    if (rd !== 32'(m_cap)) begin
      n_bad++; $display("FAIL random_capture got=%h want=%h", rd, 32'(m_cap));
    end
  endtask

  initial begin
    reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = '0;
    test_reset();
    test_rise_timing();
    test_glitch();
    test_fall_irq();
    test_clear_mode();
    test_set_wins();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pio_in_debounce_irq.md
Name: pio_in_debounce_irq

Overview:
- Parametrised successor to the fixed 5-bit edge-capture input PIO: N-channel Avalon-MM input port with a configurable synchroniser, a per-channel debounce filter, per-channel rising/falling edge selection, edge-capture latches and a masked level IRQ.
- Sits between board pins (buttons, switches) and the Nios II interconnect as an Avalon slave.

Parameters:
- WIDTH, 5, number of input channels (1..32).
- SYNC_STAGES, 2, synchroniser flops per channel (min 2).
- DEB_W, 16, debounce counter width in bits (1..32).
- DEB_RESET, 0, reset value of the debounce period register.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- address  in  3  register word address.
- chipselect  in  1  slave select.
- write_n  in  1  write strobe, active-low.
- writedata  in  32  write data.
- in_port  in  WIDTH  asynchronous pin inputs.
- readdata  out  32  registered read data.
- irq  out  1  interrupt request, active-high.

Behaviour:
- Interface: one clock. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - readdata = 0.
  - irq = 0.
  - All sync flops, stable state, counters, irq_mask, edge_capture, rise_en and fall_en = 0.
  - deb_period = DEB_RESET.
- Write strobe: wr = chipselect & ~write_n.
- Register map (unused readdata bits read 0):
  - 0 DATA: RO, debounced stable state[WIDTH-1:0].
  - 1 DEB_PERIOD: RW, [DEB_W-1:0].
  - 2 IRQ_MASK: RW.
  - 3 EDGE_CAPTURE: RW, clear semantics per Optional Feature.
  - 4 RISE_EN: RW.
  - 5 FALL_EN: RW.
  - 6, 7: read 0, writes ignored.
- Read: readdata registered every cycle from address, regardless of chipselect. Data is valid the cycle after the address is presented, so read latency is 1.
- Synchroniser: in_port passes through a SYNC_STAGES-deep flop chain per channel; synced = last stage.
- Debounce, per channel i:
  - If synced[i] == stable[i]: cnt[i] <= 0.
  - Else if cnt[i] == deb_period: stable[i] <= synced[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i] + 1.
  - Consequence: a change must persist deb_period+1 consecutive cycles. deb_period = 0 means stable follows synced one cycle later.
  - Glitches shorter than the period reset the counter and never reach stable.
- DEB_PERIOD write mid-count: the new value applies from the next cycle. If cnt already exceeds the new period, the counter continues incrementing and wraps at 2^DEB_W. Software writes DEB_PERIOD only while inputs are quiet.
- Edge detect, per channel:
  - rise = ~stable_d & stable & rise_en.
  - fall = stable_d & ~stable & fall_en.
  - stable_d is stable delayed one cycle.
  - Total pin-to-capture latency is SYNC_STAGES + deb_period + 2 cycles.
- Edge capture bit sets on a detected edge and holds until cleared by software.
- Simultaneous clear write and new edge on the same bit: set wins, bit stays 1.
- irq = |(edge_capture & irq_mask), combinational from registers. It updates the same cycle the capture or mask register changes.
- Writes to IRQ_MASK, RISE_EN and FALL_EN use writedata[WIDTH-1:0].
- Reset asserted mid-debounce: all counters and state clear. No edge is captured for a pin that is already high after reset until it falls and rises again.

Optional Feature:
- Macro: PIO_IN_BITCLEAR_EN.
- Defined: a write to EDGE_CAPTURE clears only the bits where writedata[i] = 1 (write-1-to-clear).
- Undefined: any write to EDGE_CAPTURE clears all bits, whatever writedata holds.
- The set-wins rule applies in both builds.

Test Plan:
- Reset then read all 8 addresses -> readdata 0 for each except DEB_PERIOD = DEB_RESET; irq = 0.
- DEB_PERIOD = 4, RISE_EN = 0x01, in_port[0] 0 -> 1 held -> DATA[0] = 1 exactly SYNC_STAGES+5 cycles after the change; EDGE_CAPTURE = 0x01 one cycle later.
- DEB_PERIOD = 4, 3-cycle high pulse on in_port[1] -> DATA stays 0, EDGE_CAPTURE stays 0.
- FALL_EN = 0x04, IRQ_MASK = 0x04, in_port[2] 1 -> 0 after it is stable high -> EDGE_CAPTURE = 0x04 and irq = 1. Write EDGE_CAPTURE = 0x04 -> irq = 0 the next cycle.
- PIO_IN_BITCLEAR_EN defined, EDGE_CAPTURE = 0x03, write 0x01 -> reads 0x02. Undefined build, same write -> reads 0x00.
- Clear write to EDGE_CAPTURE in the same cycle as a new rise on bit 3 -> bit 3 reads 1 afterwards.
